// File: rtl/audio_stream.sv
// audio_stream: SDRAM arbiter read client that bursts 8-bit PCM samples into a
// small FIFO and presents one unsigned sample per sample tick to apu_pwm.
module audio_stream #(
    parameter int            AN    = 24,
    parameter int            DN    = 16,
    parameter int            BURST = 8,
    parameter logic [AN-1:0] BASE  = 24'hf00000,
    parameter logic [15:0]   LEN   = 16'h4000,
    parameter int            DIV   = 1250,
    localparam int           LW    = $clog2(2*BURST)+1
) (
    input  logic          clkSYS,
    input  logic          n_reset,
    input  logic          enable,
    input  logic [DN-1:0] mem_data,
    input  logic          mem_valid,
    output logic [AN-1:0] req_addr,
    output logic [DN-1:0] req_data,
    output logic          req,
    output logic          req_wr,
    input  logic          req_ack,
    output logic [7:0]    audio,
    output logic          underrun,
    output logic [LW-1:0] level
);
    localparam int DEPTH = 2*BURST;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(BURST)+1;
    localparam int CRW   = LW+1;
    localparam int PW    = $clog2(LEN)+1;
    localparam int DVW   = $clog2(DIV);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DATA = 2'd2} state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  wcnt_r;
    logic [PW-1:0]  ptr_r, ptr_s;
    logic [DN-1:0]  fifo_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic [DVW-1:0] div_r;
    logic           started_r, byte_hi_r, req_r, underrun_r;
    logic [AN-1:0]  req_addr_r;
    logic [7:0]     audio_r;
    logic [CRW-1:0] credit_s;
    logic [DN-1:0]  head_s;
    logic           push_s, pop_s, tick_s, flush_s, last_word_s, have_s;

    assign push_s      = (state_r == S_DATA) && mem_valid;
    assign last_word_s = push_s && (wcnt_r == CW'(BURST-1));
    assign flush_s     = (state_r == S_IDLE) && !enable;
    assign have_s      = (level_r != LW'(0));
    assign tick_s      = enable && started_r && (div_r == DVW'(DIV-1));
    assign pop_s       = tick_s && have_s && byte_hi_r;
    assign head_s      = fifo_r[rd_ptr_r];

    // Credit (buffered plus owed words) and the next burst offset within the buffer.
    always_comb begin
        credit_s = CRW'(level_r);
        ptr_s    = ptr_r;
        if (state_r == S_DATA) credit_s = CRW'(level_r) + CRW'(BURST) - CRW'(wcnt_r);
        else                   credit_s = CRW'(level_r);
        if (ptr_r + PW'(BURST) >= PW'(LEN)) ptr_s = {PW{1'b0}};
        else                                ptr_s = ptr_r + PW'(BURST);
    end

    // Request FSM next state; an ack always wins so a granted burst is absorbed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (enable && (credit_s <= CRW'(BURST))) state_s = S_REQ;
                else                                     state_s = S_IDLE;
            end
            S_REQ: begin
                if (req_ack)      state_s = S_DATA;
                else if (!enable) state_s = S_IDLE;
                else              state_s = S_REQ;
            end
            S_DATA: begin
                if (last_word_s) state_s = S_IDLE;
                else             state_s = S_DATA;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state, burst word count, buffer pointer and registered request outputs.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state_r    <= S_IDLE;
            wcnt_r     <= {CW{1'b0}};
            ptr_r      <= {PW{1'b0}};
            req_r      <= 1'b0;
            req_addr_r <= BASE;
        end else begin
            state_r <= state_s;
            req_r   <= (state_s == S_REQ);
            if ((state_r == S_REQ) && req_ack) begin
                ptr_r      <= ptr_s;
                req_addr_r <= BASE + AN'(ptr_s);
                wcnt_r     <= {CW{1'b0}};
            end else if (flush_s) begin
                ptr_r      <= {PW{1'b0}};
                req_addr_r <= BASE;
                wcnt_r     <= {CW{1'b0}};
            end else if (push_s) begin
                wcnt_r <= last_word_s ? {CW{1'b0}} : wcnt_r + CW'(1);
            end
        end
    end

    // Sample word storage; entries only matter once counted by level.
    always_ff @(posedge clkSYS) begin
        if (push_s) fifo_r[wr_ptr_r] <= mem_data;
    end

    // FIFO pointers and occupancy; idle-while-disabled empties the FIFO.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sample tick and byte output. The tick counter waits for the first buffered
    // word after enable so start-up latency is not reported as an underrun.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            div_r      <= {DVW{1'b0}};
            started_r  <= 1'b0;
            byte_hi_r  <= 1'b0;
            audio_r    <= 8'h80;
            underrun_r <= 1'b0;
        end else if (flush_s) begin
            div_r      <= {DVW{1'b0}};
            started_r  <= 1'b0;
            byte_hi_r  <= 1'b0;
            audio_r    <= 8'h80;
            underrun_r <= 1'b0;
        end else begin
            if (enable && have_s) started_r <= 1'b1;
            if (enable && started_r) div_r <= tick_s ? {DVW{1'b0}} : div_r + DVW'(1);
            if (tick_s) begin
                if (!have_s) begin
                    underrun_r <= 1'b1;
                end else if (byte_hi_r) begin
                    audio_r   <= head_s[15:8];
                    byte_hi_r <= 1'b0;
                end else begin
                    audio_r   <= head_s[7:0];
                    byte_hi_r <= 1'b1;
                end
            end
        end
    end

    assign req      = req_r;
    assign req_addr = req_addr_r;
    assign req_data = {DN{1'b0}};
    assign req_wr   = 1'b0;
    assign audio    = audio_r;
    assign underrun = underrun_r;
    assign level    = level_r;

endmodule
